generic_arb_fifo: RTL and testbench

//   N-channel buffered merge point: one small FIFO per input channel feeds a single ready/valid output.

---
 rtl/generic_arb_fifo_pkg.sv | 14 +
 rtl/generic_arb_fifo_ch.sv | 52 +++++
 rtl/generic_arb_fifo.sv | 124 ++++++++++++
 tb/tb_generic_arb_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_arb_fifo_pkg.sv
// rtl/generic_arb_fifo_pkg.sv - shared types for the buffered N-channel arbiter
package generic_arb_fifo_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/generic_arb_fifo_ch.sv
// rtl/generic_arb_fifo_ch.sv - single-channel FIFO with head, full/empty and live count
module generic_arb_fifo_ch #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNTW-1:0]  o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count == CNTW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_head  = mem[rd_ptr];

  // A full FIFO refuses a push even when the same cycle pops it.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (do_pop && !do_push) count <= count - CNTW'(1);
    end
  end

endmodule

// File: rtl/generic_arb_fifo.sv
// rtl/generic_arb_fifo.sv - per-channel FIFOs merged onto one ready/valid output by RR or fixed arbitration
// Optional GENERIC_ARB_FIFO_COUNT_EN exposes the live per-channel counts on o_count.
module generic_arb_fifo
  import generic_arb_fifo_pkg::*;
#(
  parameter int        WIDTH    = 16,
  parameter int        DEPTH    = 4,
  parameter int        CHANNELS = 4,
  parameter arb_mode_e MODE     = ARB_RR,
  localparam int       CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int       CNTW     = $clog2(DEPTH) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic [CHW-1:0]            o_chan,
  output logic [CHANNELS-1:0]       o_full,
  output logic [CHANNELS-1:0]       o_empty
`ifdef GENERIC_ARB_FIFO_COUNT_EN
  ,
  output logic [CHANNELS*CNTW-1:0]  o_count
`endif
);

  logic [CHANNELS-1:0]      ch_full;
  logic [CHANNELS-1:0]      ch_empty;
  logic [CHANNELS-1:0]      ch_pop;
  logic [WIDTH-1:0]         ch_head [CHANNELS];
  logic [CHANNELS*CNTW-1:0] count_flat;

  arb_state_e     state;
  logic [CHW-1:0] lock_chan;
  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] arb_grant;
  logic           handshake;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    generic_arb_fifo_ch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_valid[c]),
      .i_pop   (ch_pop[c]),
      .i_data  (i_data[c*WIDTH +: WIDTH]),
      .o_head  (ch_head[c]),
      .o_full  (ch_full[c]),
      .o_empty (ch_empty[c]),
      .o_count (count_flat[c*CNTW +: CNTW])
    );
    assign ch_pop[c] = handshake && (o_chan == CHW'(c));
  end

`ifdef GENERIC_ARB_FIFO_COUNT_EN
  assign o_count = count_flat;
`else
  logic unused_count;
  assign unused_count = ^count_flat;
`endif

  assign o_ready   = ~ch_full;
  assign o_full    = ch_full;
  assign o_empty   = ch_empty;
  assign o_valid   = |(~ch_empty);
  assign handshake = o_valid && i_ready;

  // Round-robin scans from the slot after the last served channel.
  always_comb begin
    logic found;
    int   idx;
    arb_grant = '0;
    found     = 1'b0;
    idx       = 0;
    if (MODE == ARB_FIXED) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && !ch_empty[i]) begin
          arb_grant = CHW'(i);
          found     = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i <= CHANNELS; i++) begin
        idx = (int'(rr_ptr) + i) % CHANNELS;
        if (!found && !ch_empty[idx]) begin
          arb_grant = CHW'(idx);
          found     = 1'b1;
        end
      end
    end
  end

  assign o_chan = (state == LOCK) ? lock_chan : arb_grant;
  assign o_data = o_valid ? ch_head[o_chan] : '0;

  // A stalled beat locks the grant so data and channel hold until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ARB;
      lock_chan <= '0;
      rr_ptr    <= CHW'(CHANNELS - 1);
    end else begin
      case (state)
        ARB: begin
          if (o_valid && !i_ready) begin
            state     <= LOCK;
            lock_chan <= arb_grant;
          end
        end
        LOCK: begin
          if (i_ready) state <= ARB;
        end
        default: state <= ARB;
      endcase
      if (handshake) rr_ptr <= o_chan;
    end
  end

endmodule

// File: tb/tb_generic_arb_fifo.sv
// tb/tb_generic_arb_fifo.sv - self-checking bench running round-robin and fixed-priority instances side by side
module tb_generic_arb_fifo;
  import generic_arb_fifo_pkg::*;

  logic        clk;
  logic        i_rst;
  logic [3:0]  i_valid;
  logic [63:0] i_data;
  logic        i_ready;

  logic [3:0]  rr_ready, fx_ready, rr_full, fx_full, rr_empty, fx_empty;
  logic        rr_valid, fx_valid;
  logic [15:0] rr_data, fx_data;
  logic [1:0]  rr_chan, fx_chan;
`ifdef GENERIC_ARB_FIFO_COUNT_EN
  logic [11:0] rr_count, fx_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] sbq [8][$];

  generic_arb_fifo #(.WIDTH(16), .DEPTH(4), .CHANNELS(4), .MODE(ARB_RR)) u_rr (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rr_ready), .i_data(i_data),
    .o_valid(rr_valid), .i_ready(i_ready), .o_data(rr_data), .o_chan(rr_chan),
    .o_full(rr_full), .o_empty(rr_empty)
`ifdef GENERIC_ARB_FIFO_COUNT_EN
    , .o_count(rr_count)
`endif
  );

  generic_arb_fifo #(.WIDTH(16), .DEPTH(4), .CHANNELS(4), .MODE(ARB_FIXED)) u_fx (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(fx_ready), .i_data(i_data),
    .o_valid(fx_valid), .i_ready(i_ready), .o_data(fx_data), .o_chan(fx_chan),
    .o_full(fx_full), .o_empty(fx_empty)
`ifdef GENERIC_ARB_FIFO_COUNT_EN
    , .o_count(fx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    int          ch;
    logic [15:0] din;
    logic        ready;
    logic        e_valid;
    logic [1:0]  e_chan;
    logic [15:0] e_data;
    logic [3:0]  e_oready;
    logic [3:0]  e_full;
    logic [3:0]  e_empty;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic [3:0] v, int ch, logic [15:0] d, logic r, logic ev,
                              logic [1:0] ec, logic [15:0] ed, logic [3:0] eo,
                              logic [3:0] ef, logic [3:0] ee);
    vec_t t;
    t.valid = v; t.ch = ch; t.din = d; t.ready = r; t.e_valid = ev; t.e_chan = ec;
    t.e_data = ed; t.e_oready = eo; t.e_full = ef; t.e_empty = ee;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic [3:0] v, int ch, logic [15:0] d, logic r);
    i_valid = v;
    i_data  = '0;
    i_data[ch*16 +: 16] = d;
    i_ready = r;
  endtask

  // Scoreboard: per-DUT, per-channel queues of accepted beats.
  task automatic sb_step();
    logic [3:0]  full_pre;
    logic        ov, any;
    logic [1:0]  oc;
    logic [15:0] od;
    for (int d = 0; d < 2; d++) begin
      ov = d ? fx_valid : rr_valid;
      oc = d ? fx_chan  : rr_chan;
      od = d ? fx_data  : rr_data;
      any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        full_pre[c] = (sbq[d*4+c].size() == 4);
        if (sbq[d*4+c].size() != 0) any = 1'b1;
      end
      chk(d ? "sb_valid_fx" : "sb_valid_rr", 64'(ov), 64'(any));
      if (ov && i_ready) begin
        if (sbq[d*4+int'(oc)].size() == 0) begin
          chk(d ? "sb_pop_fx" : "sb_pop_rr", 64'(oc), 64'hDEAD);
        end else begin
          chk(d ? "sb_data_fx" : "sb_data_rr", 64'(od), 64'(sbq[d*4+int'(oc)][0]));
          void'(sbq[d*4+int'(oc)].pop_front());
        end
      end
      for (int c = 0; c < 4; c++)
        if (i_valid[c] && !full_pre[c]) sbq[d*4+c].push_back(i_data[c*16 +: 16]);
    end
  endtask

  task automatic tick_end();
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 8; i++) sbq[i].delete();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    set_in(4'b0, 0, 16'h0, 1'b0);
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  logic [1:0] exp_rr [8];
  logic [1:0] exp_fx [8];

  initial begin
    i_rst = 1'b1;
    set_in(4'b0, 0, 16'h0, 1'b0);

    vecs[0]  = mk(4'b0100, 2, 16'h0011, 1, 0, 0, 16'h0000, 4'hF, 4'h0, 4'hF);
    vecs[1]  = mk(4'b0000, 0, 16'h0000, 1, 1, 2, 16'h0011, 4'hF, 4'h0, 4'b1011);
    vecs[2]  = mk(4'b0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 4'hF, 4'h0, 4'hF);
    vecs[3]  = mk(4'b0001, 0, 16'h1000, 0, 0, 0, 16'h0000, 4'hF, 4'h0, 4'hF);
    vecs[4]  = mk(4'b0001, 0, 16'h1001, 0, 1, 0, 16'h1000, 4'hF, 4'h0, 4'b1110);
    vecs[5]  = mk(4'b0001, 0, 16'h1002, 0, 1, 0, 16'h1000, 4'hF, 4'h0, 4'b1110);
    vecs[6]  = mk(4'b0001, 0, 16'h1003, 0, 1, 0, 16'h1000, 4'hF, 4'h0, 4'b1110);
    vecs[7]  = mk(4'b0001, 0, 16'h1004, 0, 1, 0, 16'h1000, 4'b1110, 4'b0001, 4'b1110);
    vecs[8]  = mk(4'b0000, 0, 16'h0000, 1, 1, 0, 16'h1000, 4'b1110, 4'b0001, 4'b1110);
    vecs[9]  = mk(4'b0000, 0, 16'h0000, 1, 1, 0, 16'h1001, 4'hF, 4'h0, 4'b1110);
    vecs[10] = mk(4'b0000, 0, 16'h0000, 1, 1, 0, 16'h1002, 4'hF, 4'h0, 4'b1110);
    vecs[11] = mk(4'b0000, 0, 16'h0000, 1, 1, 0, 16'h1003, 4'hF, 4'h0, 4'b1110);
    vecs[12] = mk(4'b0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 4'hF, 4'h0, 4'hF);

    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_fx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    do_reset();

    // Single-channel latency and overflow vectors, identical for both modes.
    for (int k = 0; k < 13; k++) begin
      set_in(vecs[k].valid, vecs[k].ch, vecs[k].din, vecs[k].ready);
      @(negedge clk);
      chk($sformatf("v%0d_valid_rr", k), 64'(rr_valid), 64'(vecs[k].e_valid));
      chk($sformatf("v%0d_chan_rr", k),  64'(rr_chan),  64'(vecs[k].e_chan));
      chk($sformatf("v%0d_data_rr", k),  64'(rr_data),  64'(vecs[k].e_data));
      chk($sformatf("v%0d_ready_rr", k), 64'(rr_ready), 64'(vecs[k].e_oready));
      chk($sformatf("v%0d_full_rr", k),  64'(rr_full),  64'(vecs[k].e_full));
      chk($sformatf("v%0d_empty_rr", k), 64'(rr_empty), 64'(vecs[k].e_empty));
      chk($sformatf("v%0d_chan_fx", k),  64'(fx_chan),  64'(vecs[k].e_chan));
      chk($sformatf("v%0d_data_fx", k),  64'(fx_data),  64'(vecs[k].e_data));
      chk($sformatf("v%0d_full_fx", k),  64'(fx_full),  64'(vecs[k].e_full));
      tick_end();
    end

    // Two beats on every channel, then drain and compare grant order.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      i_valid = 4'hF;
      for (int c = 0; c < 4; c++) i_data[c*16 +: 16] = 16'(16'h0100 * c + b);
      i_ready = 1'b0;
      @(negedge clk);
      tick_end();
    end
    set_in(4'b0, 0, 16'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_order%0d", k), 64'(rr_chan), 64'(exp_rr[k]));
      chk($sformatf("fx_order%0d", k), 64'(fx_chan), 64'(exp_fx[k]));
      tick_end();
    end
    @(negedge clk);
    chk("drained_rr", 64'(rr_valid), 64'(0));
    tick_end();

    // Stalled ch3 beat must hold while ch0 fills up behind it.
    do_reset();
    set_in(4'b1000, 3, 16'h3333, 1'b0);
    @(negedge clk);
    tick_end();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) set_in(4'b0001, 0, 16'h0A0A, 1'b0);
      else        set_in(4'b0000, 0, 16'h0000, 1'b0);
      @(negedge clk);
      chk($sformatf("hold%0d_chan_fx", k), 64'(fx_chan), 64'd3);
      chk($sformatf("hold%0d_data_fx", k), 64'(fx_data), 64'h3333);
      chk($sformatf("hold%0d_chan_rr", k), 64'(rr_chan), 64'd3);
      tick_end();
    end
    set_in(4'b0000, 0, 16'h0000, 1'b1);
    @(negedge clk);
    chk("release_chan_fx", 64'(fx_chan), 64'd3);
    tick_end();
    @(negedge clk);
    chk("next_chan_fx", 64'(fx_chan), 64'd0);
    chk("next_data_fx", 64'(fx_data), 64'h0A0A);
    tick_end();

    // Asynchronous reset with beats buffered on ch1.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(4'b0010, 1, 16'(16'h0B00 + k), 1'b0);
      @(negedge clk);
      tick_end();
    end
    set_in(4'b0000, 0, 16'h0000, 1'b0);
    chk("pre_rst_empty", 64'(rr_empty), 64'b1101);
    i_rst = 1'b1;
    #1;
    chk("rst_valid_rr", 64'(rr_valid), 64'd0);
    chk("rst_empty_rr", 64'(rr_empty), 64'hF);
    chk("rst_empty_fx", 64'(fx_empty), 64'hF);
    chk("rst_ready_rr", 64'(rr_ready), 64'hF);
`ifdef GENERIC_ARB_FIFO_COUNT_EN
    chk("rst_count_rr", 64'(rr_count), 64'd0);
    chk("rst_count_fx", 64'(fx_count), 64'd0);
`endif
    clear_sb();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(rr_valid), 64'd0);
    tick_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
